sys_cmd_ctrl: RTL and testbench

//  Command decoder and sequencer fed by the synchronised RX byte stream, i.e. the enable_pulse/SYNC_bus

---
 rtl/sys_ctrl_pkg.sv | 27 ++
 rtl/sys_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command controller: command opcodes,
// fixed ALU operand register addresses and the sequencer state encoding.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned OPA_ADDR = 0;
   localparam int unsigned OPB_ADDR = 1;

   typedef enum logic [3:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      OP_A,
      OP_B,
      ALU_FUN,
      ALU_WAIT,
      TX_LO,
      TX_HI
   } ctrl_state_e;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// Framed command decoder: turns synchronised RX bytes into register-file and
// ALU strobes and returns read/ALU results to the TX path one byte at a time.
module sys_cmd_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int FUN_WIDTH     = 4
) (
   input  logic                     CLK,
   input  logic                     RST_n,
   input  logic                     rx_valid,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic [DATA_WIDTH-1:0]    rf_rd_data,
   input  logic                     rf_rd_valid,
   input  logic [ALU_OUT_WIDTH-1:0] alu_out,
   input  logic                     alu_valid,
   input  logic                     tx_busy,
   output logic [ADDR_WIDTH-1:0]    rf_addr,
   output logic [DATA_WIDTH-1:0]    rf_wr_data,
   output logic                     rf_wr_en,
   output logic                     rf_rd_en,
   output logic [FUN_WIDTH-1:0]     alu_fun,
   output logic                     alu_en,
   output logic                     alu_clk_en,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   output logic                     frame_err,
   output logic                     drop_err
);

   ctrl_state_e state, state_nxt;

   logic [ADDR_WIDTH-1:0] rf_addr_nxt;
   logic [DATA_WIDTH-1:0] rf_wr_data_nxt, tx_data_nxt, alu_hi, alu_hi_nxt;
   logic [FUN_WIDTH-1:0]  alu_fun_nxt;
   logic rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, alu_clk_en_nxt;
   logic tx_valid_nxt, frame_err_nxt, drop_err_nxt;
   logic tx_xfer;

   assign tx_xfer = tx_valid && !tx_busy;

   always_ff @(posedge CLK) begin
      if (!RST_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rx_valid) begin
            if      (rx_data == DATA_WIDTH'(CMD_RF_WR))   state_nxt = WR_ADDR;
            else if (rx_data == DATA_WIDTH'(CMD_RF_RD))   state_nxt = RD_ADDR;
            else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  state_nxt = OP_A;
            else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) state_nxt = ALU_FUN;
         end
         WR_ADDR:  if (rx_valid)    state_nxt = WR_DATA;
         WR_DATA:  if (rx_valid)    state_nxt = IDLE;
         RD_ADDR:  if (rx_valid)    state_nxt = RD_WAIT;
         RD_WAIT:  if (rf_rd_valid) state_nxt = TX_HI;
         OP_A:     if (rx_valid)    state_nxt = OP_B;
         OP_B:     if (rx_valid)    state_nxt = ALU_FUN;
         ALU_FUN:  if (rx_valid)    state_nxt = ALU_WAIT;
         ALU_WAIT: if (alu_valid)   state_nxt = TX_LO;
         TX_LO:    if (tx_xfer)     state_nxt = TX_HI;
         TX_HI:    if (tx_xfer)     state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   // Next values for every registered output; strobes default low so they pulse for one cycle.
   always_comb begin
      rf_addr_nxt    = rf_addr;
      rf_wr_data_nxt = rf_wr_data;
      alu_fun_nxt    = alu_fun;
      tx_data_nxt    = tx_data;
      alu_hi_nxt     = alu_hi;
      alu_clk_en_nxt = alu_clk_en;
      tx_valid_nxt   = tx_valid;
      drop_err_nxt   = drop_err;
      rf_wr_en_nxt   = 1'b0;
      rf_rd_en_nxt   = 1'b0;
      alu_en_nxt     = 1'b0;
      frame_err_nxt  = 1'b0;
      case (state)
         IDLE: if (rx_valid && state_nxt == IDLE) frame_err_nxt = 1'b1;
         WR_ADDR: if (rx_valid) rf_addr_nxt = rx_data[ADDR_WIDTH-1:0];
         WR_DATA: if (rx_valid) begin
            rf_wr_data_nxt = rx_data;
            rf_wr_en_nxt   = 1'b1;
         end
         RD_ADDR: if (rx_valid) begin
            rf_addr_nxt  = rx_data[ADDR_WIDTH-1:0];
            rf_rd_en_nxt = 1'b1;
         end
         RD_WAIT: begin
            if (rx_valid) drop_err_nxt = 1'b1;
            if (rf_rd_valid) begin
               tx_data_nxt  = rf_rd_data;
               tx_valid_nxt = 1'b1;
            end
         end
         OP_A, OP_B: if (rx_valid) begin
            rf_addr_nxt    = (state == OP_A) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
            rf_wr_data_nxt = rx_data;
            rf_wr_en_nxt   = 1'b1;
         end
         ALU_FUN: if (rx_valid) begin
            alu_fun_nxt    = rx_data[FUN_WIDTH-1:0];
            alu_en_nxt     = 1'b1;
            alu_clk_en_nxt = 1'b1;
         end
         ALU_WAIT: begin
            if (rx_valid) drop_err_nxt = 1'b1;
            if (alu_valid) begin
               alu_clk_en_nxt = 1'b0;
               tx_data_nxt    = alu_out[DATA_WIDTH-1:0];
               alu_hi_nxt     = alu_out[ALU_OUT_WIDTH-1:DATA_WIDTH];
               tx_valid_nxt   = 1'b1;
            end
         end
         // After each transfer tx_valid drops for a cycle before the next byte is offered.
         TX_LO, TX_HI: begin
            if (rx_valid) drop_err_nxt = 1'b1;
            if (tx_xfer) begin
               tx_valid_nxt = 1'b0;
               if (state == TX_LO) tx_data_nxt = alu_hi;
            end else begin
               tx_valid_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         rf_addr    <= '0;
         rf_wr_data <= '0;
         rf_wr_en   <= 1'b0;
         rf_rd_en   <= 1'b0;
         alu_fun    <= '0;
         alu_en     <= 1'b0;
         alu_clk_en <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         drop_err   <= 1'b0;
         alu_hi     <= '0;
      end else begin
         rf_addr    <= rf_addr_nxt;
         rf_wr_data <= rf_wr_data_nxt;
         rf_wr_en   <= rf_wr_en_nxt;
         rf_rd_en   <= rf_rd_en_nxt;
         alu_fun    <= alu_fun_nxt;
         alu_en     <= alu_en_nxt;
         alu_clk_en <= alu_clk_en_nxt;
         tx_data    <= tx_data_nxt;
         tx_valid   <= tx_valid_nxt;
         frame_err  <= frame_err_nxt;
         drop_err   <= drop_err_nxt;
         alu_hi     <= alu_hi_nxt;
      end
   end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scenario bench for sys_cmd_ctrl: expected strobes and TX bytes are queued as
// frames are sent and matched by a negedge monitor as the DUT produces them.
module tb_sys_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [7:0]  rf_rd_data = '0;
   logic        rf_rd_valid = 1'b0;
   logic [15:0] alu_out = '0;
   logic        alu_valid = 1'b0;
   logic        tx_busy = 1'b0;
   logic [3:0]  rf_addr;
   logic [7:0]  rf_wr_data;
   logic        rf_wr_en, rf_rd_en;
   logic [3:0]  alu_fun;
   logic        alu_en, alu_clk_en;
   logic [7:0]  tx_data;
   logic        tx_valid, frame_err, drop_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [3:0]  fun_q[$];
   logic [7:0]  tx_q[$];

   logic       prev_valid = 1'b0;
   logic       prev_xfer  = 1'b0;
   logic [7:0] prev_data  = '0;

   sys_cmd_ctrl dut (
      .CLK(CLK), .RST_n(RST_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_out(alu_out),
      .alu_valid(alu_valid), .tx_busy(tx_busy), .rf_addr(rf_addr),
      .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
      .alu_fun(alu_fun), .alu_en(alu_en), .alu_clk_en(alu_clk_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .frame_err(frame_err),
      .drop_err(drop_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard monitor: every strobe and TX transfer must match the head of its queue.
   always @(negedge CLK) begin
      if (RST_n) begin
         if (rf_wr_en) begin
            n_checks++;
            if (wr_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL rf_write unexpected: addr=%h data=%h, none expected", rf_addr, rf_wr_data);
            end else begin
               logic [11:0] exp_wr;
               exp_wr = wr_q.pop_front();
               if ({rf_addr, rf_wr_data} !== exp_wr) begin
                  n_fail++;
                  $display("[TB] FAIL rf_write: got %h/%h expected %h/%h", rf_addr, rf_wr_data, exp_wr[11:8], exp_wr[7:0]);
               end
            end
         end
         if (rf_rd_en) begin
            n_checks++;
            if (rd_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL rf_read unexpected: addr=%h", rf_addr);
            end else begin
               logic [3:0] exp_rd;
               exp_rd = rd_q.pop_front();
               if (rf_addr !== exp_rd) begin
                  n_fail++;
                  $display("[TB] FAIL rf_read addr: got %h expected %h", rf_addr, exp_rd);
               end
            end
         end
         if (alu_en) begin
            n_checks++;
            if (fun_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL alu_en unexpected: fun=%h", alu_fun);
            end else begin
               logic [3:0] exp_fun;
               exp_fun = fun_q.pop_front();
               if (alu_fun !== exp_fun || alu_clk_en !== 1'b1) begin
                  n_fail++;
                  $display("[TB] FAIL alu_start: fun=%h clk_en=%b expected fun=%h clk_en=1", alu_fun, alu_clk_en, exp_fun);
               end
            end
         end
         if (rf_wr_en || rf_rd_en || alu_en) begin
            n_checks++;
            if (int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en) > 1) begin
               n_fail++;
               $display("[TB] FAIL strobe_exclusive: wr=%b rd=%b alu=%b expected at most one", rf_wr_en, rf_rd_en, alu_en);
            end
         end
         if (tx_valid && !tx_busy) begin
            n_checks++;
            if (tx_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL tx_byte unexpected: %h", tx_data);
            end else begin
               logic [7:0] exp_tx;
               exp_tx = tx_q.pop_front();
               if (tx_data !== exp_tx) begin
                  n_fail++;
                  $display("[TB] FAIL tx_byte: got %h expected %h", tx_data, exp_tx);
               end
            end
         end
         if (prev_xfer) begin
            n_checks++;
            if (tx_valid !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL tx_gap: tx_valid=%b expected 0 after transfer", tx_valid);
            end
         end
         if (prev_valid && !prev_xfer && tx_valid) begin
            n_checks++;
            if (tx_data !== prev_data) begin
               n_fail++;
               $display("[TB] FAIL tx_stable: got %h expected %h", tx_data, prev_data);
            end
         end
      end
      prev_valid = tx_valid;
      prev_xfer  = RST_n && tx_valid && !tx_busy;
      prev_data  = tx_data;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge CLK);
      #1 rx_valid = 1'b1;
      rx_data = b;
      @(posedge CLK);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_tx_drain(input string name);
      for (int i = 0; i < 60; i++) begin
         if (tx_q.size() == 0) break;
         tick(1);
      end
      tick(2);
      n_checks++;
      if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s tx_drain: %0d bytes left, tx_valid=%b, expected 0 and 0", name, tx_q.size(), tx_valid);
      end
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      tick(3);
      n_checks++;
      if ({rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           tx_data, tx_valid, frame_err, drop_err} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: some output nonzero (tx_data=%h rf_addr=%h) expected all 0", tx_data, rf_addr);
      end
      RST_n = 1'b1;
      tick(1);
   endtask

   task automatic test_rf_write();
      wr_q.push_back({4'h5, 8'h3C});
      applyStimulus(8'hAA);
      applyStimulus(8'h05);
      applyStimulus(8'h3C);
      n_checks++;
      if (rf_wr_en !== 1'b1 || rf_addr !== 4'h5 || rf_wr_data !== 8'h3C) begin
         n_fail++;
         $display("[TB] FAIL rf_write_timing: en=%b addr=%h data=%h expected 1/5/3c", rf_wr_en, rf_addr, rf_wr_data);
      end
      tick(1);
      n_checks++;
      if (rf_wr_en !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rf_write_pulse: en=%b expected 0", rf_wr_en);
      end
      tick(3);
   endtask

   task automatic test_rf_read();
      rd_q.push_back(4'h5);
      tx_q.push_back(8'h3C);
      applyStimulus(8'hBB);
      applyStimulus(8'h05);
      n_checks++;
      if (rf_rd_en !== 1'b1 || rf_addr !== 4'h5) begin
         n_fail++;
         $display("[TB] FAIL rf_read_timing: en=%b addr=%h expected 1/5", rf_rd_en, rf_addr);
      end
      tick(2);
      rf_rd_valid = 1'b1;
      rf_rd_data  = 8'h3C;
      tick(1);
      rf_rd_valid = 1'b0;
      rf_rd_data  = 8'hEE;
      wait_tx_drain("rf_read");
   endtask

   task automatic test_alu_op();
      wr_q.push_back({4'h0, 8'h07});
      wr_q.push_back({4'h1, 8'h03});
      fun_q.push_back(4'h0);
      tx_q.push_back(8'h0A);
      tx_q.push_back(8'h00);
      applyStimulus(8'hCC);
      applyStimulus(8'h07);
      applyStimulus(8'h03);
      applyStimulus(8'h00);
      n_checks++;
      if (alu_en !== 1'b1 || alu_clk_en !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL alu_start_timing: en=%b clk_en=%b expected 1/1", alu_en, alu_clk_en);
      end
      tick(1);
      n_checks++;
      if (alu_clk_en !== 1'b1 || alu_en !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL alu_wait: clk_en=%b en=%b expected 1/0", alu_clk_en, alu_en);
      end
      tick(1);
      alu_valid = 1'b1;
      alu_out   = 16'h000A;
      n_checks++;
      if (alu_clk_en !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL alu_clk_en_valid: got %b expected 1", alu_clk_en);
      end
      tick(1);
      alu_valid = 1'b0;
      alu_out   = 16'hFFFF;
      n_checks++;
      if (alu_clk_en !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL alu_clk_en_drop: got %b expected 0", alu_clk_en);
      end
      wait_tx_drain("alu_op");
   endtask

   task automatic test_tx_busy();
      fun_q.push_back(4'h1);
      tx_q.push_back(8'h34);
      tx_q.push_back(8'h12);
      applyStimulus(8'hDD);
      applyStimulus(8'h01);
      tx_busy = 1'b1;
      tick(1);
      alu_valid = 1'b1;
      alu_out   = 16'h1234;
      tick(1);
      alu_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
            n_fail++;
            $display("[TB] FAIL tx_busy_hold[%0d]: valid=%b data=%h expected 1/34", i, tx_valid, tx_data);
         end
         tick(1);
      end
      n_checks++;
      if (tx_q.size() != 2) begin
         n_fail++;
         $display("[TB] FAIL tx_busy_pending: %0d bytes queued, expected 2", tx_q.size());
      end
      tx_busy = 1'b0;
      wait_tx_drain("tx_busy");
   endtask

   task automatic test_frame_err();
      applyStimulus(8'h55);
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL frame_err_pulse: got %b expected 1", frame_err);
      end
      tick(1);
      n_checks++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL frame_err_clear: got %b expected 0", frame_err);
      end
      wr_q.push_back({4'h3, 8'h99});
      applyStimulus(8'hAA);
      applyStimulus(8'h03);
      applyStimulus(8'h99);
      tick(2);
   endtask

   task automatic test_drop();
      fun_q.push_back(4'h2);
      tx_q.push_back(8'h05);
      tx_q.push_back(8'h00);
      applyStimulus(8'hDD);
      applyStimulus(8'h02);
      n_checks++;
      if (drop_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drop_err_idle: got %b expected 0", drop_err);
      end
      applyStimulus(8'h77);
      n_checks++;
      if (drop_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL drop_err_set: got %b expected 1", drop_err);
      end
      alu_valid = 1'b1;
      alu_out   = 16'h0005;
      tick(1);
      alu_valid = 1'b0;
      wait_tx_drain("drop");
      n_checks++;
      if (drop_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL drop_err_sticky: got %b expected 1", drop_err);
      end
   endtask

   task automatic test_back_to_back();
      wr_q.push_back({4'hA, 8'h5A});
      @(posedge CLK);
      #1 rx_valid = 1'b1;
      rx_data = 8'hAA;
      tick(1);
      rx_data = 8'h1A;
      tick(1);
      rx_data = 8'h5A;
      tick(1);
      rx_valid = 1'b0;
      tick(3);
   endtask

   task automatic test_mid_reset();
      applyStimulus(8'hAA);
      applyStimulus(8'h05);
      RST_n = 1'b0;
      tick(1);
      RST_n = 1'b1;
      n_checks++;
      if ({rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, alu_fun, alu_en, alu_clk_en,
           tx_data, tx_valid, frame_err, drop_err} !== '0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_outputs: rf_addr=%h drop_err=%b tx_data=%h expected all 0", rf_addr, drop_err, tx_data);
      end
      applyStimulus(8'h3C);
      n_checks++;
      if (rf_wr_en !== 1'b0 || frame_err !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_abandon: wr_en=%b frame_err=%b expected 0/1", rf_wr_en, frame_err);
      end
      tick(3);
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_rf_write();
      test_rf_read();
      test_alu_op();
      test_tx_busy();
      test_frame_err();
      test_drop();
      test_back_to_back();
      test_mid_reset();
      tick(2);
      n_checks++;
      if (wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_empty: wr=%0d rd=%0d alu=%0d tx=%0d outstanding, expected 0",
                  wr_q.size(), rd_q.size(), fun_q.size(), tx_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
